// File: rtl/image_scatter_ctrl.sv
// Scatter-write sequencer: streams one image segment into image_mem at strided
// addresses per `next`. Define IMAGE_SCATTER_PEND_EN to queue one early `next`.
module image_scatter_ctrl #(
  parameter int CFG_DWIDTH   = 32,
  parameter int CFG_AWIDTH   = 5,
  parameter int DEPTH_NB     = 16,
  parameter int IMG_WIDTH    = 16,
  parameter int MEM_AWIDTH   = 16,
  parameter int CFG_IW_IMG_W = 0,
  parameter int CFG_IW_START = 1,
  parameter int CFG_IW_STEP  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  output logic                          busy,
  output logic                          done,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] str_img_bus,
  input  logic                          str_img_val,
  output logic                          str_img_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [IMG_WIDTH*DEPTH_NB-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state;

  logic [16:0]           sh_img_w, sh_img_h, sh_step_p, sh_step_r;
  logic [15:0]           sh_start;
  logic [16:0]           img_w, img_h, col_cnt, row_cnt;
  logic [MEM_AWIDTH-1:0] step_p, step_r, ptr, row_base;
  logic                  accept, col_last, seg_last, start_seg, pend_now;

  // NOTE: shadow config and the write-data pipe hold no control state, so
  // they are left out of reset and stay plain enable flops.
  always_ff @(posedge clk) begin
    if (cfg_valid) begin
      if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_W)) begin
        sh_img_w <= {1'b0, cfg_data[15:0]} + 17'd1;
      end
      if (cfg_addr == CFG_AWIDTH'(CFG_IW_START)) begin
        sh_start <= cfg_data[31:16];
        sh_img_h <= {1'b0, cfg_data[15:0]} + 17'd1;
      end
      if (cfg_addr == CFG_AWIDTH'(CFG_IW_STEP)) begin
        sh_step_p <= {1'b0, cfg_data[31:16]} + 17'd1;
        sh_step_r <= {1'b0, cfg_data[15:0]} + 17'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wr_data <= str_img_bus;
  end

  assign accept    = str_img_val & str_img_rdy;
  assign col_last  = (col_cnt == img_w - 17'd1);
  assign seg_last  = col_last && (row_cnt == img_h - 17'd1);
  assign start_seg = ((state == IDLE) && next) || ((state == DONE) && pend_now);

`ifdef IMAGE_SCATTER_PEND_EN
  logic pend;

  // A next seen in DONE restarts directly, so it never needs to be stored.
  assign pend_now = pend | next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
    end else if (state == DONE) begin
      pend <= 1'b0;
    end else if (next && (state != IDLE)) begin
      pend <= 1'b1;
    end
  end
`else
  assign pend_now = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignment so every update below reads
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      str_img_rdy <= 1'b0;
      wr_val      <= 1'b0;
      wr_addr     <= '0;
      img_w       <= '0;
      img_h       <= '0;
      step_p      <= '0;
      step_r      <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      ptr         <= '0;
      row_base    <= '0;
    end else begin
      wr_val <= accept;
      done   <= 1'b0;

      if (accept) begin
        wr_addr <= ptr;
        if (!col_last) begin
          col_cnt <= col_cnt + 17'd1;
          ptr     <= ptr + step_p;
        end else begin
          col_cnt  <= '0;
          row_cnt  <= row_cnt + 17'd1;
          row_base <= row_base + step_r;
          ptr      <= row_base + step_r;
        end
        if (seg_last) begin
          state       <= DONE;
          str_img_rdy <= 1'b0;
          done        <= 1'b1;
          busy        <= pend_now;
        end
      end

      // Geometry is captured on the edge that sees next, so a config write in
      // that same cycle only reaches the following segment.
      if (start_seg) begin
        state    <= LOAD;
        busy     <= 1'b1;
        img_w    <= sh_img_w;
        img_h    <= sh_img_h;
        step_p   <= MEM_AWIDTH'(sh_step_p);
        step_r   <= MEM_AWIDTH'(sh_step_r);
        col_cnt  <= '0;
        row_cnt  <= '0;
        row_base <= MEM_AWIDTH'(sh_start);
        ptr      <= MEM_AWIDTH'(sh_start);
      end else if (state == LOAD) begin
        state       <= RUN;
        str_img_rdy <= 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
